// File: rtl/mm_refill_ctrl_if.sv
// Cache-side and memory-side signal bundle for mm_refill_ctrl.
// master = refill controller, slave = cache/memory environment.
interface mm_refill_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 20
);
    logic [ADDR_W-1:0] PC;
    logic              Req_Valid;
    logic              HitWrite;
    logic [DATA_W-1:0] MM_Rdata;
    logic              MM_Ack;
    logic              MM_Rd;
    logic [ADDR_W-1:0] MM_Addr;
    logic              Access_MM;
    logic [DATA_W-1:0] Data_MM;
    logic              Stall;
    logic [CNT_W-1:0]  CNT_MISS;
    logic [CNT_W-1:0]  CNT_STALL;

    modport master (
        input  PC, Req_Valid, HitWrite, MM_Rdata, MM_Ack,
        output MM_Rd, MM_Addr, Access_MM, Data_MM, Stall, CNT_MISS, CNT_STALL
    );

    modport slave (
        output PC, Req_Valid, HitWrite, MM_Rdata, MM_Ack,
        input  MM_Rd, MM_Addr, Access_MM, Data_MM, Stall, CNT_MISS, CNT_STALL
    );
endinterface

// File: rtl/mm_refill_ctrl.sv
// I-cache miss refill controller with saturating miss/stall counters.
// Define MM_PREFETCH_EN to add the one-entry next-word prefetch buffer.
module mm_refill_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 20
) (
    input logic              CLK,
    input logic              RESET,
    mm_refill_ctrl_if.master bus
);
`ifdef MM_PREFETCH_EN
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, FILL = 2'd2, PF_REQ = 2'd3} state_t;
    localparam logic [ADDR_W-1:0] WORD_STEP = {{(ADDR_W-3){1'b0}}, 3'd4};
`else
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, FILL = 2'd2} state_t;
`endif

    state_t            state_r;
    logic              mm_rd_r;
    logic              access_mm_r;
    logic              stall_r;
    logic [ADDR_W-1:0] mm_addr_r;
    logic [DATA_W-1:0] data_mm_r;
    logic [CNT_W-1:0]  cnt_miss_r;
    logic [CNT_W-1:0]  cnt_stall_r;
    logic              miss_s;
    logic [ADDR_W-1:0] pc_word_s;
`ifdef MM_PREFETCH_EN
    logic              pf_valid_r;
    logic [ADDR_W-1:0] pf_addr_r;
    logic [DATA_W-1:0] pf_data_r;
    logic              pend_r;
    logic [ADDR_W-1:0] pend_addr_r;
    logic              pf_hit_s;
`endif

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) return v;
        else    return v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Miss detection, word-aligned lookup address and buffer match
    always_comb begin
        miss_s    = bus.Req_Valid & ~bus.HitWrite;
        pc_word_s = bus.PC & {{(ADDR_W-2){1'b1}}, 2'b00};
`ifdef MM_PREFETCH_EN
        pf_hit_s = 1'b0;
        if (pf_valid_r && (pf_addr_r == pc_word_s)) pf_hit_s = 1'b1;
        else                                        pf_hit_s = 1'b0;
`endif
    end

    // Refill FSM with registered outputs and saturating counters
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_r     <= IDLE;
            mm_rd_r     <= 1'b0;
            access_mm_r <= 1'b0;
            stall_r     <= 1'b0;
            mm_addr_r   <= {ADDR_W{1'b0}};
            data_mm_r   <= {DATA_W{1'b0}};
            cnt_miss_r  <= {CNT_W{1'b0}};
            cnt_stall_r <= {CNT_W{1'b0}};
`ifdef MM_PREFETCH_EN
            pf_valid_r  <= 1'b0;
            pf_addr_r   <= {ADDR_W{1'b0}};
            pf_data_r   <= {DATA_W{1'b0}};
            pend_r      <= 1'b0;
            pend_addr_r <= {ADDR_W{1'b0}};
`endif
        end else begin
            if (stall_r) cnt_stall_r <= sat_inc(cnt_stall_r);
            case (state_r)
                IDLE: begin
                    access_mm_r <= 1'b0;
                    if (miss_s) begin
                        cnt_miss_r <= sat_inc(cnt_miss_r);
                        mm_addr_r  <= pc_word_s;
                        stall_r    <= 1'b1;
`ifdef MM_PREFETCH_EN
                        pf_valid_r <= 1'b0;
                        if (pf_hit_s) begin
                            data_mm_r   <= pf_data_r;
                            access_mm_r <= 1'b1;
                            state_r     <= FILL;
                        end else begin
                            mm_rd_r <= 1'b1;
                            state_r <= REQ;
                        end
`else
                        mm_rd_r <= 1'b1;
                        state_r <= REQ;
`endif
                    end
                end
                REQ: begin
                    if (bus.MM_Ack) begin
                        data_mm_r   <= bus.MM_Rdata;
                        access_mm_r <= 1'b1;
                        mm_rd_r     <= 1'b0;
                        state_r     <= FILL;
                    end
                end
                FILL: begin
                    access_mm_r <= 1'b0;
                    stall_r     <= 1'b0;
`ifdef MM_PREFETCH_EN
                    mm_addr_r   <= mm_addr_r + WORD_STEP;
                    mm_rd_r     <= 1'b1;
                    state_r     <= PF_REQ;
`else
                    state_r     <= IDLE;
`endif
                end
`ifdef MM_PREFETCH_EN
                PF_REQ: begin
                    // A miss raised during the prefetch waits for its ack
                    if (bus.MM_Ack) begin
                        if (pend_r) begin
                            pend_r <= 1'b0;
                            if (pend_addr_r == mm_addr_r) begin
                                data_mm_r   <= bus.MM_Rdata;
                                access_mm_r <= 1'b1;
                                mm_rd_r     <= 1'b0;
                                state_r     <= FILL;
                            end else begin
                                mm_addr_r <= pend_addr_r;
                                state_r   <= REQ;
                            end
                        end else begin
                            pf_addr_r  <= mm_addr_r;
                            pf_data_r  <= bus.MM_Rdata;
                            pf_valid_r <= 1'b1;
                            mm_rd_r    <= 1'b0;
                            state_r    <= IDLE;
                        end
                    end else if (miss_s && !pend_r) begin
                        pend_r      <= 1'b1;
                        pend_addr_r <= pc_word_s;
                        cnt_miss_r  <= sat_inc(cnt_miss_r);
                        stall_r     <= 1'b1;
                    end
                end
`endif
                default: begin
                    state_r     <= IDLE;
                    mm_rd_r     <= 1'b0;
                    access_mm_r <= 1'b0;
                    stall_r     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.MM_Rd     = mm_rd_r;
    assign bus.MM_Addr   = mm_addr_r;
    assign bus.Access_MM = access_mm_r;
    assign bus.Data_MM   = data_mm_r;
    assign bus.Stall     = stall_r;
    assign bus.CNT_MISS  = cnt_miss_r;
    assign bus.CNT_STALL = cnt_stall_r;
endmodule

// File: doc/mm_refill_ctrl.md
# mm_refill_ctrl

Miss-refill controller between the instruction cache (Cache_Direct / Cache_2way / Cache_Fully) and main memory. It detects a cache miss, stalls the front end, and issues a word read to memory with a request/acknowledge handshake. It returns the fetched word to the cache with a one-cycle fill strobe on Access_MM, and keeps miss and stall counters. An optional next-word prefetch buffer hides the latency of sequential misses.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- CNT_W, 20, width of CNT_MISS / CNT_STALL
- CLK  in  1  clock, rising edge
- RESET  in  1  synchronous reset, active-low (0 = reset on CLK rising edge)
- PC  in  ADDR_W  fetch address under lookup
- Req_Valid  in  1  cache lookup valid this cycle
- HitWrite  in  1  cache lookup hit; miss = Req_Valid & ~HitWrite
- MM_Rdata  in  DATA_W  memory read data, valid with MM_Ack
- MM_Ack  in  1  memory read complete, one-cycle pulse
- MM_Rd  out  1  memory read request, held until MM_Ack
- MM_Addr  out  ADDR_W  word-aligned read address, stable while MM_Rd=1
- Access_MM  out  1  fill strobe: cache writes Data_MM into the line for PC
- Data_MM  out  DATA_W  fill data, valid while Access_MM=1
- Stall  out  1  front end must hold PC
- CNT_MISS  out  CNT_W  accepted misses, saturating
- CNT_STALL  out  CNT_W  cycles with Stall=1, saturating

## Operation
- States: IDLE, REQ, FILL, plus PF_REQ (with macro only). All outputs are registered.
- IDLE: a sampled miss latches {PC[ADDR_W-1:2],2'b00} into MM_Addr, increments CNT_MISS, and moves to REQ.
- REQ: MM_Rd=1 and Stall=1. When MM_Ack is seen: capture MM_Rdata into Data_MM, move to FILL.
- FILL: Access_MM=1 for exactly one cycle, Stall=1. Next state is IDLE, or PF_REQ when prefetch is enabled.
- In REQ and FILL, Req_Valid, HitWrite and PC are ignored.
- MM_Ack is ignored in IDLE and FILL.
- Counters saturate at all-ones and never wrap.
- CNT_STALL increments in every cycle where the registered Stall=1.
- Reset (RESET=0 at an edge), including mid-refill:
  - state goes to IDLE; MM_Rd, Access_MM and Stall go to 0; MM_Addr and Data_MM go to 0; counters go to 0; the prefetch buffer is invalidated.
  - An MM_Ack that arrives after reset is ignored.

## Timing
- Reset values: every output 0.
- A miss sampled at edge t gives MM_Rd=1 and Stall=1 from t+1.
- An MM_Ack sampled at edge a gives Access_MM=1 at a+1, then Stall=0 and IDLE at a+2.
- Minimum miss-to-fill is 2 cycles (ack in the first REQ cycle).
- MM_Rd drops in the cycle after the ack edge.
- MM_Ack and a new miss in the same cycle: the ack is consumed and the miss is ignored. The cache re-presents it after Stall falls.

## Configuration
- MM_PREFETCH_EN defined:
  - After FILL, enter PF_REQ. Issue MM_Rd for MM_Addr+4 (wraps modulo 2^ADDR_W) with Stall=0.
  - On ack, store {addr, data, valid=1} in a one-entry buffer and go to IDLE.
  - IDLE miss that matches the valid buffer address: FILL next cycle with the buffer data, no MM_Rd, CNT_MISS still increments, buffer invalidated.
  - Miss sampled in PF_REQ: it is latched, CNT_MISS increments, and Stall=1 next cycle. On the prefetch ack:
    - latched address equals the prefetch address: go to FILL with MM_Rdata;
    - otherwise: discard the data and go to REQ for the latched address.
  - A non-matching IDLE miss invalidates the buffer.
- MM_PREFETCH_EN undefined: no PF_REQ and no buffer; MM_Rd is asserted only in REQ.

## Test plan
Memory model: ack 2 cycles after MM_Rd rises, MM_Rdata = MM_Addr ^ 32'hA5A5_0000.
- Reset hold then release, Req_Valid=0 -> all outputs 0, CNT_MISS=0, CNT_STALL=0.
- Miss at PC=32'h10 -> MM_Rd with MM_Addr=32'h10; Access_MM=1 with Data_MM=32'hA5A5_0010 exactly 3 cycles after the miss edge; CNT_MISS=1; CNT_STALL=3.
- Hit (HitWrite=1) at PC=0 for 10 cycles -> no MM_Rd, Stall=0, CNT_MISS=0.
- RESET=0 while in REQ, then a late MM_Ack -> IDLE, no Access_MM, counters 0.
- Force CNT_MISS to 20'hFFFFF, then miss -> stays 20'hFFFFF.
- MM_PREFETCH_EN: miss at 32'h0, wait for the prefetch to finish, then miss at 32'h4 -> Access_MM one cycle after the miss, Data_MM=32'hA5A5_0004, no MM_Rd; CNT_MISS=2.
